// File: rtl/button_prompt_checker.sv
// Response side of the random button-prompt game: latches a prompt code,
// waits for all buttons to be released, then scores the next press as a pass
// or a strike (timeout also strikes) until the game is defused or exploded.
module button_prompt_checker #(
  parameter int unsigned ROUNDS         = 8,
  parameter int unsigned MAX_STRIKES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] code_in,
  input  logic [5:0] btn1,
  input  logic [5:0] btn2,
  output logic [3:0] prompt,
  output logic       prompt_valid,
  output logic       pass,
  output logic       fail,
  output logic [7:0] score,
  output logic [7:0] strikes,
  output logic       defused,
  output logic       exploded
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_REL,
    S_ARMED,
    S_RESULT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           prompt_q, prompt_d;
  logic                 prompt_valid_q, prompt_valid_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic [7:0]           score_q, score_d;
  logic [7:0]           strikes_q, strikes_d;
  logic                 defused_q, defused_d;
  logic                 exploded_q, exploded_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [11:0]          btn_q, btn_d;

  logic [11:0]          b;
  logic [11:0]          edges;
  logic [11:0]          prompt_mask;
  logic                 wrong_press;
  logic                 right_press;
  logic                 timed_out;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d      = state_q;
    prompt_d     = prompt_q;
    pass_d       = 1'b0;
    fail_d       = 1'b0;
    score_d      = score_q;
    strikes_d    = strikes_q;
    defused_d    = defused_q;
    exploded_d   = exploded_q;
    timer_d      = timer_q;

    b            = {btn2, btn1};
    edges        = b & ~btn_q;
    btn_d        = b;
    prompt_mask  = 12'd1 << prompt_q;
    wrong_press  = |(edges & ~prompt_mask);
    right_press  = |(edges & prompt_mask);
    timed_out    = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          score_d   = '0;
          strikes_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (code_in <= 4'd11) begin
          prompt_d = code_in;
          state_d  = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (b == '0) begin
          timer_d = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // A stray edge wins over a simultaneous correct edge
        if (wrong_press || (timed_out && !right_press)) begin
          fail_d    = 1'b1;
          strikes_d = (strikes_q == '1) ? strikes_q : strikes_q + 8'd1;
          state_d   = S_RESULT;
        end else if (right_press) begin
          pass_d  = 1'b1;
          score_d = (score_q == '1) ? score_q : score_q + 8'd1;
          state_d = S_RESULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (score_q == 8'(ROUNDS)) begin
          defused_d = 1'b1;
          state_d   = S_DONE;
        end else if (strikes_q == 8'(MAX_STRIKES)) begin
          exploded_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (start) begin
          defused_d  = 1'b0;
          exploded_d = 1'b0;
          score_d    = '0;
          strikes_d  = '0;
          state_d    = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    prompt_valid_d = (state_d == S_WAIT_REL) || (state_d == S_ARMED);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      prompt_q       <= '0;
      prompt_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      score_q        <= '0;
      strikes_q      <= '0;
      defused_q      <= 1'b0;
      exploded_q     <= 1'b0;
      timer_q        <= '0;
      btn_q          <= '1;
    end else begin
      state_q        <= state_d;
      prompt_q       <= prompt_d;
      prompt_valid_q <= prompt_valid_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      score_q        <= score_d;
      strikes_q      <= strikes_d;
      defused_q      <= defused_d;
      exploded_q     <= exploded_d;
      timer_q        <= timer_d;
      btn_q          <= btn_d;
    end
  end

  assign prompt       = prompt_q;
  assign prompt_valid = prompt_valid_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign score        = score_q;
  assign strikes      = strikes_q;
  assign defused      = defused_q;
  assign exploded     = exploded_q;

endmodule

// File: tb/tb_button_prompt_checker.sv
// Directed bench for button_prompt_checker with ROUNDS=2, MAX_STRIKES=2,
// TIMEOUT_CYCLES=16. Inputs change on the falling edge, outputs are checked
// on the falling edge after each rising edge.
module tb_button_prompt_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] code_in;
  logic [5:0] btn1;
  logic [5:0] btn2;
  logic [3:0] prompt;
  logic       prompt_valid;
  logic       pass;
  logic       fail;
  logic [7:0] score;
  logic [7:0] strikes;
  logic       defused;
  logic       exploded;

  int unsigned n_cmp;
  int unsigned n_err;

  button_prompt_checker #(
    .ROUNDS        (2),
    .MAX_STRIKES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .code_in     (code_in),
    .btn1        (btn1),
    .btn2        (btn2),
    .prompt      (prompt),
    .prompt_valid(prompt_valid),
    .pass        (pass),
    .fail        (fail),
    .score       (score),
    .strikes     (strikes),
    .defused     (defused),
    .exploded    (exploded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then settle at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_btns(input logic [11:0] v);
    btn1 = v[5:0];
    btn2 = v[11:6];
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".prompt"},   32'(prompt), 0);
    check_eq({tag, ".pv"},       32'(prompt_valid), 0);
    check_eq({tag, ".pass"},     32'(pass), 0);
    check_eq({tag, ".fail"},     32'(fail), 0);
    check_eq({tag, ".score"},    32'(score), 0);
    check_eq({tag, ".strikes"},  32'(strikes), 0);
    check_eq({tag, ".defused"},  32'(defused), 0);
    check_eq({tag, ".exploded"}, 32'(exploded), 0);
  endtask

  // From LOAD with buttons released: latch code, then arm
  task automatic arm(input logic [3:0] c);
    code_in = c;
    step();
    check_eq("arm.prompt", 32'(prompt), 32'(c));
    check_eq("arm.pv_wait", 32'(prompt_valid), 1);
    step();
    check_eq("arm.pv_armed", 32'(prompt_valid), 1);
  endtask

  // Press while ARMED, check result cycle, release and leave RESULT
  task automatic press(input logic [11:0] v, input logic ep, input logic ef,
                       input logic [7:0] esc, input logic [7:0] est);
    set_btns(v);
    step();
    check_eq("press.pass", 32'(pass), 32'(ep));
    check_eq("press.fail", 32'(fail), 32'(ef));
    check_eq("press.score", 32'(score), 32'(esc));
    check_eq("press.strikes", 32'(strikes), 32'(est));
    check_eq("press.pv", 32'(prompt_valid), 0);
    set_btns('0);
    step();
    check_eq("post.pass", 32'(pass), 0);
    check_eq("post.fail", 32'(fail), 0);
  endtask

  // Entered ARMED at the last edge: 15 quiet cycles, fail on the 16th
  task automatic expect_timeout(input logic [7:0] est);
    int unsigned early;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (fail || pass) early++;
    end
    check_eq("timeout.early_pulse", early, 0);
    step();
    check_eq("timeout.fail", 32'(fail), 1);
    check_eq("timeout.pass", 32'(pass), 0);
    check_eq("timeout.strikes", 32'(strikes), 32'(est));
    step();
    check_eq("timeout.fail_end", 32'(fail), 0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start   = 1'b1;
    code_in = 4'd3;
    set_btns('0);

    // Reset held with start high
    for (int i = 0; i < 3; i++) begin
      step();
      check_all_zero("reset");
    end

    // Game 1
    rst = 1'b0;
    step();
    check_eq("start.pv_load", 32'(prompt_valid), 0);
    start = 1'b0;
    arm(4'd3);
    press(12'h008, 1'b1, 1'b0, 8'd1, 8'd0);

    arm(4'd8);
    press(12'h101, 1'b0, 1'b1, 8'd1, 8'd1);

    code_in = 4'd15;
    set_btns(12'h010);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bad_code.pv", 32'(prompt_valid), 0);
      check_eq("bad_code.prompt", 32'(prompt), 8);
    end
    code_in = 4'd4;
    step();
    check_eq("code4.prompt", 32'(prompt), 4);
    check_eq("code4.pv", 32'(prompt_valid), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("held.pass", 32'(pass), 0);
      check_eq("held.pv", 32'(prompt_valid), 1);
    end
    set_btns('0);
    step();
    check_eq("released.pass", 32'(pass), 0);
    press(12'h010, 1'b1, 1'b0, 8'd2, 8'd1);
    check_eq("g1.defused", 32'(defused), 1);
    check_eq("g1.exploded", 32'(exploded), 0);
    step();
    step();
    check_eq("g1.defused_held", 32'(defused), 1);
    check_eq("g1.score_held", 32'(score), 2);

    // Game 2: two timeouts
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("g2.defused_clr", 32'(defused), 0);
    check_eq("g2.score_clr", 32'(score), 0);
    check_eq("g2.strikes_clr", 32'(strikes), 0);
    arm(4'd5);
    expect_timeout(8'd1);
    arm(4'd11);
    expect_timeout(8'd2);
    check_eq("g2.exploded", 32'(exploded), 1);
    check_eq("g2.defused", 32'(defused), 0);
    step();
    step();
    check_eq("g2.exploded_held", 32'(exploded), 1);

    // Game 3: two correct presses, start ignored while armed
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("g3.exploded_clr", 32'(exploded), 0);
    check_eq("g3.strikes_clr", 32'(strikes), 0);
    arm(4'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("g3.start_ignored_pv", 32'(prompt_valid), 1);
    check_eq("g3.start_ignored_prompt", 32'(prompt), 1);
    press(12'h002, 1'b1, 1'b0, 8'd1, 8'd0);
    arm(4'd10);
    press(12'h400, 1'b1, 1'b0, 8'd2, 8'd0);
    check_eq("g3.defused", 32'(defused), 1);

    // Game 4: reset while armed with a correct press pending
    start = 1'b1;
    step();
    start = 1'b0;
    arm(4'd7);
    set_btns(12'h080);
    rst = 1'b1;
    step();
    check_all_zero("mid_rst");
    step();
    check_all_zero("mid_rst2");
    rst = 1'b0;
    set_btns('0);
    step();
    check_all_zero("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
